// File: rtl/seg7_scan_driver_ca_if.sv
// Bus bundle between the display driver and its client: the load request
// with its value and decimal points, and the status/segment/digit outputs.
interface seg7_scan_driver_ca_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) ();
    logic [BIN_W-1:0]  bin_in;
    logic              load;
    logic [DIGITS-1:0] dp_in;
    logic              busy;
    logic              overflow;
    logic [7:0]        seg_out;
    logic [DIGITS-1:0] dig_sel;

    modport master (
        output bin_in, load, dp_in,
        input  busy, overflow, seg_out, dig_sel
    );

    modport slave (
        input  bin_in, load, dp_in,
        output busy, overflow, seg_out, dig_sel
    );
endinterface

// File: rtl/seg7_scan_driver_ca.sv
// Common-anode multiplexed 7-segment driver. A loaded binary value is turned
// into BCD one bit per clock (shift-add-3), then committed to the display
// registers, which a free-running scanner puts onto the shared segment bus.
module seg7_scan_driver_ca #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic clk,
    input  logic rst,
    seg7_scan_driver_ca_if.slave bus
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    // Segments a..g, active low, for one BCD digit; anything else is dark.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h01;
            4'd1:    seg_code = 7'h4F;
            4'd2:    seg_code = 7'h12;
            4'd3:    seg_code = 7'h06;
            4'd4:    seg_code = 7'h4C;
            4'd5:    seg_code = 7'h24;
            4'd6:    seg_code = 7'h20;
            4'd7:    seg_code = 7'h0F;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h04;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam int          IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int          DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t            state, state_next;
    logic [BIN_W-1:0]  bin_sh;
    logic [BCD_W-1:0]  acc, acc_adj, disp_bcd;
    logic [DIGITS-1:0] dp_cap, dp_reg;
    logic              ovf_cap, overflow_r, busy_r;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_bit;
    logic [3:0]        adj_nib, scan_nib;
    logic              all_zero;
    logic [IDX_W-1:0]  scan_idx;
    logic [DIV_W-1:0]  div_cnt;
    logic [7:0]        seg_r, seg_next;
    logic [DIGITS-1:0] dig_r, dig_next;

    assign last_bit     = (bit_cnt == CNT_W'(BIN_W - 1));
    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;
    assign bus.seg_out  = seg_r;
    assign bus.dig_sel  = dig_r;

    // Conversion state register; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Conversion sequencing: a load is only honoured from IDLE, so loads while busy vanish.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.load) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add 3 to every nibble that is 5 or more, ahead of the next left shift.
    always_comb begin
        acc_adj = acc;
        adj_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            adj_nib = acc[4*i +: 4];
            if (adj_nib >= 4'd5) acc_adj[4*i +: 4] = adj_nib + 4'd3;
        end
    end

    // Capture, shift-add-3 datapath and commit of the finished digits to the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sh     <= '0;
            acc        <= '0;
            disp_bcd   <= '0;
            dp_cap     <= '0;
            dp_reg     <= '0;
            ovf_cap    <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            busy_r <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        bin_sh  <= bus.bin_in;
                        dp_cap  <= bus.dp_in;
                        acc     <= '0;
                        bit_cnt <= '0;
                        ovf_cap <= (64'(bus.bin_in) >= LIMIT);
                    end
                end
                SHIFT: begin
                    acc     <= {acc_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
                    bin_sh  <= bin_sh << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                COMMIT: begin
                    disp_bcd   <= acc;
                    dp_reg     <= dp_cap;
                    overflow_r <= ovf_cap;
                end
                default: ;
            endcase
        end
    end

    // Pattern for the digit under the scan index: dashes, blanking, or the digit code.
    always_comb begin
        seg_next = 8'hFF;
        dig_next = '1;
        all_zero = 1'b1;
        scan_nib = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            scan_nib = disp_bcd[4*i +: 4];
            all_zero = all_zero && (scan_nib == 4'd0);
            if (IDX_W'(i) == scan_idx) begin
                dig_next[i] = 1'b0;
                if (overflow_r)
                    seg_next = 8'hFE;
                else if ((BLANK_LZ != 0) && (i > 0) && all_zero)
                    seg_next = dp_reg[i] ? 8'h7F : 8'hFF;
                else if (scan_nib > 4'd9)
                    seg_next = 8'hFF;
                else
                    seg_next = {~dp_reg[i], seg_code(scan_nib)};
            end
        end
    end

    // Free-running scan; segments and enable are registered together so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            scan_idx <= '0;
            seg_r    <= 8'hFF;
            dig_r    <= '1;
        end else begin
            seg_r <= seg_next;
            dig_r <= dig_next;
            if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                div_cnt  <= '0;
                scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver_ca.sv
// Bench for the multiplexed display driver: directed and random loads, with
// every scanned digit compared against a decimal-arithmetic display model.
module tb_seg7_scan_driver_ca;

    localparam int BIN_W    = 14;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seg7_scan_driver_ca_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    seg7_scan_driver_ca #(
        .BIN_W(BIN_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] enc_tab [10];
    int         model_val    = 0;
    logic [3:0] model_dp     = 4'd0;
    bit         seg_chk      = 1'b0;
    int         pos_cnt      = 0;
    int         eight_seen   = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected segment byte for digit i of value v, worked out in decimal.
    function automatic logic [7:0] expSeg(input int v, input logic [3:0] dp, input int i);
        int p;
        p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (v >= 10000) return 8'hFE;
        if (i > 0 && v < p) return dp[i] ? 8'h7F : 8'hFF;
        return {~dp[i], enc_tab[(v / p) % 10][6:0]};
    endfunction

    // Clocks since reset release define which digit the scanner should show.
    always @(posedge clk) begin
        if (rst) pos_cnt = 0;
        else     pos_cnt = pos_cnt + 1;
    end

    // Continuous scan monitor: enable position every cycle, segments when the model is valid.
    always @(negedge clk) begin
        int idx;
        if (!rst && pos_cnt >= 1) begin
            idx = ((pos_cnt - 1) / SCAN_DIV) % DIGITS;
            checkOutput("dig_sel", 32'(bus.dig_sel), 32'(4'(~(4'b0001 << idx))));
            if (seg_chk) begin
                checkOutput($sformatf("seg_dig%0d", idx), 32'(bus.seg_out),
                            32'(expSeg(model_val, model_dp, idx)));
                checkOutput("overflow", 32'(bus.overflow), 32'(model_val >= 10000));
            end
            if (bus.seg_out == 8'h80) eight_seen++;
        end
    end

    task automatic applyStimulus(input int val, input logic [3:0] dp, input bit extra, input int val2);
        int busy_cnt;
        int guard;
        @(negedge clk);
        seg_chk    = 1'b0;
        bus.bin_in = BIN_W'(val);
        bus.dp_in  = dp;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        busy_cnt = bus.busy ? 1 : 0;
        if (extra) begin
            bus.bin_in = BIN_W'(val2);
            bus.load   = 1'b1;
            @(negedge clk);
            bus.load = 1'b0;
            if (bus.busy) busy_cnt++;
        end
        guard = 0;
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            guard++;
        end
        checkOutput($sformatf("busy_len_%0d", val), 32'(busy_cnt), 32'd15);
        model_val = val;
        model_dp  = dp;
        @(negedge clk);
        seg_chk = 1'b1;
        checkOutput($sformatf("ovf_after_%0d", val), 32'(bus.overflow), 32'(val >= 10000));
        repeat (2 * SCAN_DIV * DIGITS) @(negedge clk);
    endtask

    initial begin
        enc_tab[0] = 8'b1000_0001; enc_tab[1] = 8'b1100_1111;
        enc_tab[2] = 8'b1001_0010; enc_tab[3] = 8'b1000_0110;
        enc_tab[4] = 8'b1100_1100; enc_tab[5] = 8'b1010_0100;
        enc_tab[6] = 8'b1010_0000; enc_tab[7] = 8'b1000_1111;
        enc_tab[8] = 8'b1000_0000; enc_tab[9] = 8'b1000_0100;

        bus.bin_in = '0;
        bus.load   = 1'b0;
        bus.dp_in  = '0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_seg", 32'(bus.seg_out), 32'hFF);
        checkOutput("rst_dig", 32'(bus.dig_sel), 32'hF);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);

        model_val = 0;
        model_dp  = 4'd0;
        seg_chk   = 1'b1;
        rst       = 1'b0;
        @(negedge clk);
        checkOutput("first_dig", 32'(bus.dig_sel), 32'b1110);
        checkOutput("first_seg", 32'(bus.seg_out), 32'b1000_0001);
        repeat (20) @(negedge clk);

        applyStimulus(1234, 4'b0000, 1'b0, 0);
        applyStimulus(7, 4'b0000, 1'b0, 0);
        applyStimulus(1005, 4'b0000, 1'b0, 0);
        applyStimulus(10000, 4'b1111, 1'b0, 0);
        applyStimulus(9999, 4'b0000, 1'b0, 0);
        applyStimulus(42, 4'b0100, 1'b1, 99);
        applyStimulus(16383, 4'b0001, 1'b0, 0);
        applyStimulus(0, 4'b1010, 1'b0, 0);

        for (int n = 0; n < 12; n++) begin
            applyStimulus(int'($urandom_range(0, 16383)), 4'($urandom_range(0, 15)), 1'b0, 0);
        end

        // Reset in the middle of converting 8888 must abort without showing it.
        applyStimulus(3, 4'b0000, 1'b0, 0);
        eight_seen = 0;
        @(negedge clk);
        seg_chk    = 1'b0;
        bus.bin_in = BIN_W'(8888);
        bus.dp_in  = 4'b0000;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_seg", 32'(bus.seg_out), 32'hFF);
        checkOutput("abort_dig", 32'(bus.dig_sel), 32'hF);
        model_val = 0;
        model_dp  = 4'd0;
        seg_chk   = 1'b1;
        rst       = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("abort_idle", 32'(bus.busy), 32'd0);
        checkOutput("no_8888", 32'(eight_seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver_ca.md
Name: seg7_scan_driver_ca

Overview:
- Multi-digit, time-multiplexed, common-anode 7-segment display driver for the clock demo.
- Accepts an unsigned binary value on a load strobe and converts it to BCD sequentially (shift-add-3, one bit per clock).
- Holds the converted digits and scans them onto one shared segment bus with active-low digit enables.
- Adds leading-zero blanking, per-digit decimal points and out-of-range indication.

Parameters:
- BIN_W, 14, width of binary input.
- DIGITS, 4, number of display digits (1..8).
- SCAN_DIV, 50000, clocks each digit is held active during scan (>=1).
- BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- bin_in  in  BIN_W  unsigned value to display; sampled on accepted load.
- load  in  1  single-cycle request to convert bin_in.
- dp_in  in  DIGITS  decimal-point enables, 1 = lit; bit i is digit i; sampled with load.
- busy  out  1  high while a conversion is in progress.
- overflow  out  1  high while the displayed value is >= 10^DIGITS.
- seg_out  out  8  segment bus, active low: [7]=dp,[6]=a,[5]=b,[4]=c,[3]=d,[2]=e,[1]=f,[0]=g.
- dig_sel  out  DIGITS  digit enables, active low; bit 0 = rightmost (least significant) digit.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - busy=0, overflow=0, seg_out=8'hFF, dig_sel=all ones.
  - Display BCD registers = 0, dp registers = 0, scan index = 0, divider = 0, FSM = IDLE.
- Conversion FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
  - IDLE: load=1 captures bin_in and dp_in, clears the BCD accumulator and sets busy=1 at the next edge. Go to SHIFT.
  - SHIFT: exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left one bit, MSB of the binary value first.
  - COMMIT: one cycle. Copy the accumulator to the display registers, update overflow, clear busy. Return to IDLE.
  - Timing: busy is high for BIN_W+1 cycles. The new digits are visible on seg_out at most 1 cycle after busy falls.
  - load while busy: ignored; no queueing.
  - rst during SHIFT/COMMIT: conversion aborts and all state takes its reset values.
- Overflow:
  - Compare the captured value against 10^DIGITS at capture, using an arithmetic width of at least 32 bits.
  - If >= 10^DIGITS, COMMIT sets overflow=1 and every digit displays a dash (8'b11111110, dp forced off).
  - Otherwise overflow=0.
- Scan:
  - The divider counts 0..SCAN_DIV-1 continuously. At terminal count, the index advances 0->1->...->DIGITS-1->0.
  - seg_out and dig_sel are registered from the current index: dig_sel has only bit[index] low.
  - Both outputs change on the same edge, so no cycle ever pairs one digit's segments with another digit's enable.
  - Scan is independent of conversion: busy does not pause it.
- Digit encoding (active low, dp=1 means off):
  - 0=1000_0001, 1=1100_1111, 2=1001_0010, 3=1000_0110, 4=1100_1100.
  - 5=1010_0100, 6=1010_0000, 7=1000_1111, 8=1000_0000, 9=1000_0100.
  - Non-BCD nibble: 8'hFF.
- Blanking (BLANK_LZ=1):
  - Digit i is blanked (8'hFF) when i > 0 and all digits i..DIGITS-1 are zero. Digit 0 is never blanked.
  - Zeros below the highest non-zero digit are shown.
  - dp_in[i]=1 on a blanked digit still lights the dp only: seg_out=8'b0111_1111.
- Decimal point: seg_out[7] = ~dp_reg[index] unless overflow.

Test Plan:
- Bench settings: DIGITS=4, BIN_W=14, SCAN_DIV=4.
- Reset, then release -> during reset seg_out=8'hFF, dig_sel=4'b1111. First cycle after release: dig_sel=4'b1110, seg_out=8'b1000_0001. Digits 1-3 show 8'hFF. The pattern 1110,1101,1011,0111 repeats with 4 clocks per digit.
- load with bin_in=1234 -> busy high exactly 15 cycles. Afterwards: digit3=1100_1111, digit2=1001_0010, digit1=1000_0110, digit0=1100_1100; overflow=0.
- load 7 -> only digit0 lit (1000_1111). load 1005 -> digits 1,0,0,5 all shown: digit2 and digit1 = 1000_0001.
- load 10000 -> overflow=1, all four digits 1111_1110. Then load 9999 -> overflow=0, every digit 1000_0100 (no 8 encoding appears).
- load 42 with dp_in=4'b0100, then a second load of 99 one cycle later while busy -> the 99 is ignored. Display shows 42, and digit2 (blanked) outputs 0111_1111.
- Assert rst mid-SHIFT after loading 8888 -> busy=0 next edge, display returns to blanked "0", and no 8888 ever appears.
